// File: rtl/a2_instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : a2_instr_fetch
//  Purpose  : Instruction-fetch stage with writable imem, PC and run control
//             (IDLE/RUN/HALT). Define A2_JUMP_EN to build JMP redirect.
//  Revision : 1.0  initial release
// ============================================================================
module a2_instr_fetch #(
    parameter int PC_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            imem_we,
    input  logic [PC_W-1:0] imem_waddr,
    input  logic [7:0]      imem_wdata,
    output logic            WriteReg_out,
    output logic            SEtoReg_out,
    output logic [7:0]      instruction_out,
    output logic [PC_W-1:0] pc_out,
    output logic            running,
    output logic            halted
);
    localparam int         c_DEPTH   = 1 << PC_W;
    localparam logic [1:0] c_OP_MOVI = 2'b00;
    localparam logic [1:0] c_OP_HALT = 2'b10;
    localparam logic [7:0] c_BUBBLE  = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_mem [c_DEPTH];
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_seq;
    logic [PC_W-1:0] w_pc_fetch_nxt;
    logic [PC_W-1:0] w_pc_out_nxt;
    logic [7:0]      w_fetch;
    logic [7:0]      w_instr_nxt;
    logic            w_wr_nxt;
    logic            w_se_nxt;

    // Memory is deliberately outside the reset domain so contents survive reset
    always_ff @(posedge clk) begin
        if (imem_we && (r_state == S_IDLE)) begin
            r_mem[imem_waddr] <= imem_wdata;
        end
    end

    assign w_fetch  = r_mem[r_pc];
    assign w_pc_seq = r_pc + PC_W'(1);

`ifdef A2_JUMP_EN
    localparam logic [1:0] c_OP_JMP = 2'b11;
    assign w_pc_fetch_nxt = (w_fetch[7:6] == c_OP_JMP) ? w_fetch[PC_W-1:0] : w_pc_seq;
`else
    assign w_pc_fetch_nxt = w_pc_seq;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_pc_out_nxt = pc_out;
        w_instr_nxt  = instruction_out;
        w_wr_nxt     = WriteReg_out;
        w_se_nxt     = SEtoReg_out;
        case (r_state)
            S_IDLE: begin
                w_pc_nxt = '0;
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    // A HALT already on the outputs retires to a bubble this edge
                    if (instruction_out[7:6] == c_OP_HALT) begin
                        w_state_nxt = S_HALT;
                        w_instr_nxt = c_BUBBLE;
                        w_wr_nxt    = 1'b0;
                        w_se_nxt    = 1'b0;
                    end else begin
                        w_instr_nxt  = w_fetch;
                        w_wr_nxt     = ~w_fetch[7];
                        w_se_nxt     = (w_fetch[7:6] == c_OP_MOVI);
                        w_pc_out_nxt = r_pc;
                        w_pc_nxt     = w_pc_fetch_nxt;
                    end
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = '0;
                w_instr_nxt = c_BUBBLE;
                w_wr_nxt    = 1'b0;
                w_se_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_pc            <= '0;
            pc_out          <= '0;
            instruction_out <= c_BUBBLE;
            WriteReg_out    <= 1'b0;
            SEtoReg_out     <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            pc_out          <= w_pc_out_nxt;
            instruction_out <= w_instr_nxt;
            WriteReg_out    <= w_wr_nxt;
            SEtoReg_out     <= w_se_nxt;
        end
    end

    assign running = (r_state == S_RUN);
    assign halted  = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: doc/a2_instr_fetch.md
# a2_instr_fetch

Instruction-fetch stage that drives the IF/ID pipeline register. It holds a writable instruction memory and a program counter, and a small run-control state machine sequences fetch. Each cycle it presents one 8-bit instruction with its pre-decoded WriteReg/SEtoReg control bits on the same signal set the IF/ID register captures. It supports stall, jump redirect and halt.

## Interface
- PC_W, 6: program-counter width; memory depth is 2**PC_W; legal range 3..6.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state except memory.
- start  in  1  single-cycle pulse; leaves IDLE and begins fetch at address 0.
- stall  in  1  holds PC and all outputs while in RUN.
- imem_we  in  1  memory write enable; honoured only in IDLE.
- imem_waddr  in  PC_W  memory write address.
- imem_wdata  in  8  memory write data.
- WriteReg_out  out  1  register-file write enable for the presented instruction.
- SEtoReg_out  out  1  selects the sign-extended immediate as write data.
- instruction_out  out  8  presented instruction.
- pc_out  out  PC_W  address of the presented instruction.
- running  out  1  high in RUN.
- halted  out  1  high in HALT.

## Operation
- Instruction format: [7:6] opcode, [5:3] rd, [2:0] rs/imm3. For JMP, [5:0] is the target.
- Decode, registered with the instruction:
  - 00 MOVI: WriteReg=1, SEtoReg=1.
  - 01 ADD: WriteReg=1, SEtoReg=0.
  - 10 HALT: WriteReg=0, SEtoReg=0.
  - 11 JMP: WriteReg=0, SEtoReg=0.
- Bubble: instruction_out=8'h00, WriteReg_out=0, SEtoReg_out=0.
- States: IDLE, RUN, HALT.
  - IDLE: outputs bubble, pc=0, memory writable. start -> RUN.
  - RUN, not stalled: each cycle, outputs <= decode(mem[pc]) and pc_out <= pc.
    - Next pc for JMP: instruction[PC_W-1:0].
    - Next pc otherwise: pc+1 mod 2**PC_W (wraps from 2**PC_W-1 to 0).
  - RUN, HALT fetched: the HALT instruction is presented once, then state -> HALT.
  - HALT: outputs bubble; only reset exits.
- Memory:
  - Read is combinational from pc.
  - Write is synchronous and only in IDLE; imem_we in RUN or HALT is ignored.
  - Contents are not cleared by reset.
- Simultaneous events:
  - start with imem_we in IDLE: the write completes and RUN begins at address 0, using the updated word.
  - stall in IDLE or HALT has no effect.
  - start outside IDLE is ignored.
- Reset mid-operation: immediate return to IDLE with bubble outputs, pc=0, running=0, halted=0. Memory is preserved.

## Timing
- Reset values: WriteReg_out=0, SEtoReg_out=0, instruction_out=0, pc_out=0, running=0, halted=0, state=IDLE.
- start sampled at edge N: running=1 after edge N; mem[0] is presented after edge N+1.
- Throughput is one instruction per cycle in RUN without stall.
- JMP penalty is zero bubbles: the target instruction is presented on the edge after the JMP.
- Stall sampled high at edge N: all outputs and pc hold through edge N. Fetch resumes at the first edge where stall is low.
- HALT presented after edge N: bubble and halted=1 after edge N+1.

## Configuration
- A2_JUMP_EN defined: opcode 11 redirects the PC as described above.
- A2_JUMP_EN undefined: opcode 11 is presented with WriteReg=0 and SEtoReg=0, pc increments normally, and no redirect logic is built.

## Test plan
- Reset and load: assert reset, then write mem[0]=8'h0E, mem[1]=8'h4A, mem[2]=8'h80, then pulse start. Required outputs:
  - Before start: all outputs 0.
  - After start: (1,1,8'h0E,pc 0), then (0... no: (1,0,8'h4A,pc 1), then (0,0,8'h80,pc 2).
  - Next cycle: bubble with halted=1.
- Jump (A2_JUMP_EN): mem[0]=8'hC5, mem[5]=8'h0B, mem[6]=8'h80. Required sequence: pc_out 0, 5, 6, then halted=1. Without the macro, pc_out runs 0, 1, 2, ...
- Stall: hold stall high for 3 cycles while mem[1] is presented. Outputs stay at mem[1] for 4 cycles total, then mem[2] follows.
- Wrap: PC_W=3, memory filled with 8'h40. pc_out runs 7, 0, 1, and running stays 1.
- Ignored write and mid-run reset:
  - imem_we asserted in RUN leaves memory unchanged.
  - Asynchronous reset pulse mid-cycle clears outputs before the next edge.
  - A restart then fetches the original mem[0].
